// File: rtl/ex_wb_stage.sv
// Execute-to-writeback register stage: two-entry skid buffer carrying ALU results with zero/neg flags.
// One-cycle latency; in_ready/out_valid come from the state register only, so out_ready never reaches in_ready.
module ex_wb_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_we,
    output logic              out_zero,
    output logic              out_neg,
    output logic [15:0]       stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  rd;
        logic              we;
        logic              zero;
        logic              neg;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    entry_t r_main;
    entry_t r_skid;
    entry_t w_in_entry;
    logic   w_accept;
    logic   w_pop;
    logic   w_load_main_in;
    logic   w_load_main_skid;
    logic   w_load_skid;

    // Flags are frozen at capture so writeback never recomputes them from the data path.
    assign w_in_entry = '{data: in_data,
                          rd:   in_rd,
                          we:   in_we,
                          zero: (in_data == '0),
                          neg:  in_data[DATA_W-1]};

    assign in_ready  = (r_state != S_FULL);
    assign out_valid = (r_state != S_EMPTY);
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_next_state   = S_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && !w_pop) begin
                    w_next_state = S_FULL;
                    w_load_skid  = 1'b1;
                end else if (w_pop && !w_accept) begin
                    w_next_state = S_EMPTY;
                end else if (w_accept && w_pop) begin
                    w_load_main_in = 1'b1;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_next_state     = S_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_next_state = S_EMPTY;
        endcase
        if (flush) begin
            w_next_state     = S_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load_main_in) begin
                r_main <= w_in_entry;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign out_data = r_main.data;
    assign out_rd   = r_main.rd;
    assign out_we   = r_main.we;
    assign out_zero = r_main.zero;
    assign out_neg  = r_main.neg;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: reset, streaming, backpressure, flush and stall-counter saturation.
module tb_ex_wb_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_rd;
    logic        in_we;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_rd;
    logic        out_we;
    logic        out_zero;
    logic        out_neg;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ex_wb_stage #(.DATA_W(16), .REG_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rd     (in_rd),
        .in_we     (in_we),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_we    (out_we),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic [2:0] rd, input logic we);
        in_valid = 1'b1;
        in_data  = d;
        in_rd    = rd;
        in_we    = we;
    endtask

    task automatic chk_head(input string tag, input logic [15:0] d, input logic [2:0] rd,
                            input logic zero, input logic neg);
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_dat"}, {16'd0, out_data}, {16'd0, d});
        chk({tag, "_rd"}, {29'd0, out_rd}, {29'd0, rd});
        chk({tag, "_zero"}, {31'd0, out_zero}, {31'd0, zero});
        chk({tag, "_neg"}, {31'd0, out_neg}, {31'd0, neg});
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rd     = '0;
        in_we     = 1'b0;
        out_ready = 1'b0;

        #3;
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("rst_dat", {16'd0, out_data}, 32'd0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
        step();
        rst = 1'b0;

        // Streaming with out_ready high
        out_ready = 1'b1;
        drive(16'h0001, 3'd1, 1'b1);
        step();
        chk_head("s0", 16'h0001, 3'd1, 1'b0, 1'b0);
        chk("s0_we", {31'd0, out_we}, 32'd1);
        drive(16'h8000, 3'd2, 1'b1);
        step();
        chk_head("s1", 16'h8000, 3'd2, 1'b0, 1'b1);
        drive(16'h0000, 3'd3, 1'b1);
        step();
        chk_head("s2", 16'h0000, 3'd3, 1'b1, 1'b0);
        in_valid = 1'b0;
        step();
        chk("s_drain_vld", {31'd0, out_valid}, 32'd0);
        chk("s_stall", {16'd0, stall_cnt}, 32'd0);

        // Backpressure: fill to FULL, hold a third word, then drain
        out_ready = 1'b0;
        drive(16'h1234, 3'd4, 1'b1);
        step();
        chk_head("bp0", 16'h1234, 3'd4, 1'b0, 1'b0);
        chk("bp0_stall", {16'd0, stall_cnt}, 32'd0);
        drive(16'h00F0, 3'd5, 1'b1);
        step();
        chk("bp1_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp1_stall", {16'd0, stall_cnt}, 32'd1);
        drive(16'h0F0F, 3'd6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_dat", {16'd0, out_data}, 32'h1234);
            chk("bp_hold_stall", {16'd0, stall_cnt}, 32'(2 + i));
        end
        out_ready = 1'b1;
        step();
        chk_head("bp_d1", 16'h00F0, 3'd5, 1'b0, 1'b0);
        chk("bp_d1_rdy", {31'd0, in_ready}, 32'd1);
        step();
        chk_head("bp_d2", 16'h0F0F, 3'd6, 1'b0, 1'b0);
        in_valid = 1'b0;
        step();
        chk("bp_end_vld", {31'd0, out_valid}, 32'd0);
        chk("bp_end_stall", {16'd0, stall_cnt}, 32'd4);

        // Simultaneous accept and pop in ONE
        drive(16'h0005, 3'd1, 1'b1);
        step();
        chk_head("ap0", 16'h0005, 3'd1, 1'b0, 1'b0);
        drive(16'h0006, 3'd2, 1'b1);
        step();
        chk_head("ap1", 16'h0006, 3'd2, 1'b0, 1'b0);
        chk("ap1_rdy", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        step();
        chk("ap_end_vld", {31'd0, out_valid}, 32'd0);

        // Flush while FULL with a valid input present
        out_ready = 1'b0;
        drive(16'h00A1, 3'd1, 1'b1);
        step();
        drive(16'h00A2, 3'd2, 1'b1);
        step();
        chk("fl_pre_rdy", {31'd0, in_ready}, 32'd0);
        chk("fl_pre_stall", {16'd0, stall_cnt}, 32'd5);
        flush = 1'b1;
        drive(16'h00A3, 3'd3, 1'b1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_vld", {31'd0, out_valid}, 32'd0);
        chk("fl_rdy", {31'd0, in_ready}, 32'd1);
        chk("fl_stall", {16'd0, stall_cnt}, 32'd6);
        step();
        chk("fl_nocap_vld", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        drive(16'hB001, 3'd7, 1'b1);
        step();
        chk_head("fl_next", 16'hB001, 3'd7, 1'b0, 1'b1);
        in_valid = 1'b0;
        step();
        chk("fl_end_stall", {16'd0, stall_cnt}, 32'd6);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        drive(16'h00C1, 3'd3, 1'b1);
        step();
        drive(16'h00C2, 3'd4, 1'b1);
        step();
        in_valid = 1'b0;
        chk("ra_full_rdy", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("ra_vld", {31'd0, out_valid}, 32'd0);
        chk("ra_rdy", {31'd0, in_ready}, 32'd1);
        chk("ra_dat", {16'd0, out_data}, 32'd0);
        chk("ra_rd", {29'd0, out_rd}, 32'd0);
        chk("ra_we", {31'd0, out_we}, 32'd0);
        chk("ra_stall", {16'd0, stall_cnt}, 32'd0);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        drive(16'h00AA, 3'd5, 1'b0);
        step();
        chk_head("ra_aa", 16'h00AA, 3'd5, 1'b0, 1'b0);
        chk("ra_aa_we", {31'd0, out_we}, 32'd0);
        in_valid = 1'b0;
        step();
        chk("ra_end_vld", {31'd0, out_valid}, 32'd0);

        // Stall counter saturation
        out_ready = 1'b0;
        drive(16'h7777, 3'd6, 1'b1);
        step();
        in_valid = 1'b0;
        chk("sat_start", {16'd0, stall_cnt}, 32'd0);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", {16'd0, stall_cnt}, 32'h0000FFFE);
        step();
        chk("sat_ffff", {16'd0, stall_cnt}, 32'h0000FFFF);
        repeat (5) step();
        chk("sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);
        chk("sat_dat", {16'd0, out_data}, 32'h7777);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
